de2i_150_qsys_nios2_oci_dct_packer: RTL

DE2I_150_QSYS_NIOS2_OCI_DCT_PACKER -- requirements
Module: de2i_150_qsys_nios2_oci_dct_packer

---
 rtl/de2i_150_qsys_nios2_oci_dct_pkg.sv | 15 +
 rtl/de2i_150_qsys_nios2_oci_dct_packer_if.sv | 23 ++
 rtl/de2i_150_qsys_nios2_oci_dct_outreg.sv | 33 +++
 rtl/de2i_150_qsys_nios2_oci_dct_packer.sv | 88 ++++++++
 4 files changed

// File: rtl/de2i_150_qsys_nios2_oci_dct_pkg.sv
// Shared widths and sequencing states for the trace symbol packer.
package de2i_150_qsys_nios2_oci_dct_pkg;

  localparam int DCT_SYM_W = 2;
  localparam int DCT_SLOTS = 15;
  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/de2i_150_qsys_nios2_oci_dct_packer_if.sv
// Symbol input and packed-word output handshakes of the trace packer.
interface de2i_150_qsys_nios2_oci_dct_packer_if;
  import de2i_150_qsys_nios2_oci_dct_pkg::*;

  logic                 sym_valid;
  logic [DCT_SYM_W-1:0] sym_data;
  logic                 sym_ready;
  logic                 dct_valid;
  logic [DCT_BUF_W-1:0] dct_buffer;
  logic [DCT_CNT_W-1:0] dct_count;
  logic                 dct_ready;

  modport master (
    output sym_valid, sym_data, dct_ready,
    input  sym_ready, dct_valid, dct_buffer, dct_count
  );

  modport slave (
    input  sym_valid, sym_data, dct_ready,
    output sym_ready, dct_valid, dct_buffer, dct_count
  );

endinterface

// File: rtl/de2i_150_qsys_nios2_oci_dct_outreg.sv
// Single-entry output holding register; contents persist after the word is taken.
module de2i_150_qsys_nios2_oci_dct_outreg
  import de2i_150_qsys_nios2_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buffer,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 dct_ready,
  output logic                 dct_valid,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 out_free
);

  assign out_free = !dct_valid || dct_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      dct_valid  <= 1'b1;
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
    end else if (dct_ready) begin
      dct_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/de2i_150_qsys_nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-slot words and drains them at end of test.
//   state | meaning
//   ACCUM | accepting symbols, words emitted when full or flushed
//   DRAIN | input closed, remaining partial word pushed out
//   ENDED | everything drained, terminal until reset
module de2i_150_qsys_nios2_oci_dct_packer
  import de2i_150_qsys_nios2_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic test_ending,
  output logic test_has_ended,
  de2i_150_qsys_nios2_oci_dct_packer_if.slave bus
);

  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(DCT_SLOTS);

  dct_state_e           state, state_next;
  logic [DCT_BUF_W-1:0] acc, acc_next;
  logic [DCT_CNT_W-1:0] acc_cnt, acc_cnt_next;
  logic                 flush_pending, flush_pending_next;
  logic                 accept, move, out_free;

  assign bus.sym_ready  = (state == ACCUM) && (acc_cnt < FULL_CNT);
  assign accept         = bus.sym_valid && bus.sym_ready;
  assign test_has_ended = (state == ENDED);

  assign move = out_free && ((acc_cnt == FULL_CNT) ||
                             (flush_pending && acc_cnt != '0) ||
                             (state == DRAIN && acc_cnt != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ACCUM;
      acc           <= '0;
      acc_cnt       <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_next;
      acc           <= acc_next;
      acc_cnt       <= acc_cnt_next;
      flush_pending <= flush_pending_next;
    end
  end

  always_comb begin
    state_next         = state;
    acc_next           = acc;
    acc_cnt_next       = acc_cnt;
    flush_pending_next = flush_pending;

    case (state)
      ACCUM:   if (test_ending) state_next = DRAIN;
      DRAIN:   if (acc_cnt == '0 && !bus.dct_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = ACCUM;
    endcase

    // Clearing first lets a symbol taken in the move cycle fall into slot 0.
    if (move) begin
      acc_next     = '0;
      acc_cnt_next = '0;
    end
    if (accept) begin
      acc_next[{acc_cnt_next, 1'b0} +: DCT_SYM_W] = bus.sym_data;
      acc_cnt_next = acc_cnt_next + 1'b1;
    end

    // A flush raised during a move only applies to the symbol that started the new word.
    if (move) flush_pending_next = flush && accept;
    else      flush_pending_next = (flush_pending || flush) && (acc_cnt_next != '0);
  end

  de2i_150_qsys_nios2_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (move),
    .load_buffer (acc),
    .load_count  (acc_cnt),
    .dct_ready   (bus.dct_ready),
    .dct_valid   (bus.dct_valid),
    .dct_buffer  (bus.dct_buffer),
    .dct_count   (bus.dct_count),
    .out_free    (out_free)
  );

endmodule
